// File: rtl/byte_bus_pkg.sv
// Shared byte-bus types and sizing constants, common to the arbiter and the byte demux.
package byte_bus_pkg;

  localparam int BB_REQS      = 2;
  localparam int BB_DATA_BYTE = 4;
  localparam int BB_ADDR_SIZE = 32;
  localparam int BB_DATA_W    = BB_DATA_BYTE * 8;
  localparam int BB_BURST_LEN = 4;

  // Index width for n requesters; a single bit is kept even when n is 1 or 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                    is_write;
    logic [BB_DATA_BYTE-1:0] write_mask;
    logic [BB_ADDR_SIZE-1:0] addr;
    logic [BB_DATA_W-1:0]    write_data;
  } byte_req_t;

endpackage

// File: rtl/byte_arbiter_if.sv
// Byte-bus bundle between REQS requesters, the arbiter and the downstream memory port.
interface byte_arbiter_if import byte_bus_pkg::*; #(parameter int REQS = BB_REQS) ();

  logic [REQS-1:0]                   reqEnable;
  logic [REQS-1:0]                   reqIsWrite;
  logic [REQS-1:0][BB_DATA_BYTE-1:0] reqWriteMask;
  logic [REQS-1:0][BB_ADDR_SIZE-1:0] reqAddr;
  logic [REQS-1:0][BB_DATA_W-1:0]    reqWriteData;
  logic [REQS-1:0][BB_DATA_W-1:0]    reqReadData;
  logic [REQS-1:0]                   reqHold;

  logic                    memEnable;
  logic                    memIsWrite;
  logic [BB_DATA_BYTE-1:0] memWriteMask;
  logic [BB_ADDR_SIZE-1:0] memAddr;
  logic [BB_DATA_W-1:0]    memWriteData;
  logic [BB_DATA_W-1:0]    memReadData;
  logic                    memHold;

  // Master drives requests and plays the memory; slave is the arbiter.
  modport master (
    output reqEnable, reqIsWrite, reqWriteMask, reqAddr, reqWriteData, memReadData, memHold,
    input  reqReadData, reqHold, memEnable, memIsWrite, memWriteMask, memAddr, memWriteData
  );

  modport slave (
    input  reqEnable, reqIsWrite, reqWriteMask, reqAddr, reqWriteData, memReadData, memHold,
    output reqReadData, reqHold, memEnable, memIsWrite, memWriteMask, memAddr, memWriteData
  );

endinterface

// File: rtl/byte_arb_rr_pick.sv
// Rotating-priority picker: first requester after last_i (wrapping) with its request bit set.
module byte_arb_rr_pick import byte_bus_pkg::*; #(
  parameter int REQS = BB_REQS,
  localparam int IDX_W = idx_w(REQS)
) (
  input  logic [REQS-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] gnt_o,
  output logic             valid_o
);

  int   cand;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= REQS; k++) begin
      cand = (int'(last_i) + k) % REQS;
      if (!found && req_i[cand]) begin
        gnt_o = IDX_W'(cand);
        found = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/byte_arbiter.sv
// Round-robin arbiter sharing one byte-bus memory port among REQS requesters.
// Optional burst grants are enabled by defining BYTE_ARB_BURST_EN.
module byte_arbiter import byte_bus_pkg::*; #(
  parameter int REQS = BB_REQS
`ifdef BYTE_ARB_BURST_EN
  , parameter int BURST_LEN = BB_BURST_LEN
`endif
) (
  input logic           clk_i,
  input logic           rst_i,
  byte_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(REQS);
  typedef logic [IDX_W-1:0] idx_t;

  logic      lock_q, lock_d;
  idx_t      lock_idx_q, lock_idx_d;
  idx_t      last_gnt_q, last_gnt_d;
  idx_t      rd_owner_q, rd_owner_d;
  idx_t      pick_idx, grant;
  logic      pick_valid, gnt_valid, accept;
  byte_req_t req_vec [REQS];
  byte_req_t gnt_req;

  byte_arb_rr_pick #(.REQS(REQS)) u_pick (
    .req_i   (bus.reqEnable),
    .last_i  (last_gnt_q),
    .gnt_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef BYTE_ARB_BURST_EN
  localparam int CNT_W = idx_w(BURST_LEN) + 1;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  always_comb begin
    for (int i = 0; i < REQS; i++) begin
      req_vec[i] = '{is_write:   bus.reqIsWrite[i],
                     write_mask: bus.reqWriteMask[i],
                     addr:       bus.reqAddr[i],
                     write_data: bus.reqWriteData[i]};
    end
  end

  // A stalled request keeps the port; a running burst keeps it while its owner still asks.
  always_comb begin
    grant     = pick_idx;
    gnt_valid = pick_valid;
    if (lock_q) begin
      grant     = lock_idx_q;
      gnt_valid = bus.reqEnable[lock_idx_q];
    end
`ifdef BYTE_ARB_BURST_EN
    else if (burst_cnt_q != '0 && bus.reqEnable[last_gnt_q]) begin
      grant     = last_gnt_q;
      gnt_valid = 1'b1;
    end
`endif
    if (!gnt_valid) grant = '0;
    gnt_req = req_vec[grant];
  end

  always_comb begin
    bus.memEnable    = gnt_valid;
    bus.memIsWrite   = gnt_req.is_write;
    bus.memWriteMask = gnt_req.write_mask;
    bus.memAddr      = gnt_req.addr;
    bus.memWriteData = gnt_req.write_data;
    accept           = gnt_valid & ~bus.memHold;
    for (int i = 0; i < REQS; i++) begin
      bus.reqHold[i]     = bus.reqEnable[i] & ((idx_t'(i) != grant) | bus.memHold);
      bus.reqReadData[i] = (idx_t'(i) == rd_owner_q) ? bus.memReadData : '0;
    end
  end

  always_comb begin
    lock_d     = gnt_valid & bus.memHold;
    lock_idx_d = (gnt_valid & bus.memHold) ? grant : lock_idx_q;
    last_gnt_d = accept ? grant : last_gnt_q;
    rd_owner_d = (accept && !gnt_req.is_write) ? grant : rd_owner_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      last_gnt_q <= idx_t'(REQS - 1);
      rd_owner_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      last_gnt_q <= last_gnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

`ifdef BYTE_ARB_BURST_EN
  // burst_cnt counts accepts of the current owner; wrapping to zero hands the port on.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (accept) begin
      if (grant == last_gnt_q && burst_cnt_q != '0)
        burst_cnt_d = (burst_cnt_q == CNT_W'(BURST_LEN - 1)) ? '0 : burst_cnt_q + 1'b1;
      else
        burst_cnt_d = (BURST_LEN > 1) ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) burst_cnt_q <= '0;
    else       burst_cnt_q <= burst_cnt_d;
  end
`endif

  // A stalled requester must keep asking until the memory releases it.
  assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> bus.reqEnable[lock_idx_q]);

endmodule

// File: tb/tb_byte_arbiter.sv
// Directed self-checking bench for byte_arbiter with two requesters.
module tb_byte_arbiter;
  import byte_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  byte_arbiter_if #(.REQS(2)) bus ();

  byte_arbiter #(.REQS(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.reqEnable    = '0;
    bus.reqIsWrite   = '0;
    bus.reqWriteMask = '0;
    bus.reqAddr      = '0;
    bus.reqWriteData = '0;
    bus.memReadData  = '0;
    bus.memHold      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.memReadData = 32'h5A5A_5A5A;
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++; if (bus.memEnable !== 1'b0) begin bad++; $display("FAIL reset_memEnable: got %0b want 0", bus.memEnable); end
    total++; if (bus.reqHold !== 2'b00) begin bad++; $display("FAIL reset_reqHold: got %0b want 00", bus.reqHold); end
    total++; if (bus.reqReadData[0] !== 32'h5A5A_5A5A) begin bad++; $display("FAIL reset_rdata0: got %0h want 5a5a5a5a", bus.reqReadData[0]); end
    total++; if (bus.reqReadData[1] !== 32'h0) begin bad++; $display("FAIL reset_rdata1: got %0h want 0", bus.reqReadData[1]); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.reqEnable[0] = 1'b1;
    bus.reqAddr[0]   = 32'h10;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h10) begin bad++; $display("FAIL read_addr: got %0h want 10", bus.memAddr); end
    total++; if (bus.memEnable !== 1'b1) begin bad++; $display("FAIL read_enable: got %0b want 1", bus.memEnable); end
    total++; if (bus.memIsWrite !== 1'b0) begin bad++; $display("FAIL read_iswrite: got %0b want 0", bus.memIsWrite); end
    total++; if (bus.reqHold !== 2'b00) begin bad++; $display("FAIL read_hold: got %0b want 00", bus.reqHold); end
    tick();
    bus.reqEnable[0] = 1'b0;
    bus.memReadData  = 32'hAABB_CCDD;
    @(negedge clk);
    total++; if (bus.reqReadData[0] !== 32'hAABB_CCDD) begin bad++; $display("FAIL read_data0: got %0h want aabbccdd", bus.reqReadData[0]); end
    total++; if (bus.reqReadData[1] !== 32'h0) begin bad++; $display("FAIL read_data1: got %0h want 0", bus.reqReadData[1]); end
    total++; if (bus.memEnable !== 1'b0) begin bad++; $display("FAIL read_idle: got %0b want 0", bus.memEnable); end
  endtask

  task automatic test_rotation();
`ifdef BYTE_ARB_BURST_EN
    int exp_seq [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    int exp_seq [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    logic [31:0] exp_addr;
    logic [1:0]  exp_hold;
    do_reset();
    bus.reqEnable  = 2'b11;
    bus.reqIsWrite = 2'b11;
    bus.reqAddr[0] = 32'h100;
    bus.reqAddr[1] = 32'h200;
    for (int c = 0; c < 8; c++) begin
      exp_addr = (exp_seq[c] == 0) ? 32'h100 : 32'h200;
      exp_hold = (exp_seq[c] == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++; if (bus.memAddr !== exp_addr) begin bad++; $display("FAIL rot_addr[%0d]: got %0h want %0h", c, bus.memAddr, exp_addr); end
      total++; if (bus.reqHold !== exp_hold) begin bad++; $display("FAIL rot_hold[%0d]: got %0b want %0b", c, bus.reqHold, exp_hold); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    bus.reqAddr[0]   = 32'h100;
    bus.reqAddr[1]   = 32'h200;
    bus.reqEnable[0] = 1'b1;
    tick();
    bus.reqEnable   = 2'b10;
    bus.memHold     = 1'b1;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h200) begin bad++; $display("FAIL lock_first: got %0h want 200", bus.memAddr); end
    total++; if (bus.reqHold !== 2'b10) begin bad++; $display("FAIL lock_first_hold: got %0b want 10", bus.reqHold); end
    tick();
    bus.reqEnable = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.memAddr !== 32'h200) begin bad++; $display("FAIL lock_addr[%0d]: got %0h want 200", c, bus.memAddr); end
      total++; if (bus.reqHold !== 2'b11) begin bad++; $display("FAIL lock_hold[%0d]: got %0b want 11", c, bus.reqHold); end
      tick();
    end
    bus.memHold = 1'b0;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h200) begin bad++; $display("FAIL lock_release: got %0h want 200", bus.memAddr); end
    total++; if (bus.reqHold !== 2'b01) begin bad++; $display("FAIL lock_release_hold: got %0b want 01", bus.reqHold); end
    tick();
    bus.reqEnable = 2'b01;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h100) begin bad++; $display("FAIL lock_next: got %0h want 100", bus.memAddr); end
    total++; if (bus.reqHold !== 2'b00) begin bad++; $display("FAIL lock_next_hold: got %0b want 00", bus.reqHold); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.reqEnable       = 2'b11;
    bus.reqIsWrite      = 2'b10;
    bus.reqAddr[0]      = 32'h40;
    bus.reqAddr[1]      = 32'h80;
    bus.reqWriteData[1] = 32'h1234_5678;
    bus.reqWriteMask[1] = 4'b0011;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h40) begin bad++; $display("FAIL b2b_rd_addr: got %0h want 40", bus.memAddr); end
    total++; if (bus.memIsWrite !== 1'b0) begin bad++; $display("FAIL b2b_rd_iswrite: got %0b want 0", bus.memIsWrite); end
    tick();
    bus.reqEnable   = 2'b10;
    bus.memReadData = 32'hCAFE_F00D;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h80) begin bad++; $display("FAIL b2b_wr_addr: got %0h want 80", bus.memAddr); end
    total++; if (bus.memIsWrite !== 1'b1) begin bad++; $display("FAIL b2b_wr_iswrite: got %0b want 1", bus.memIsWrite); end
    total++; if (bus.memWriteData !== 32'h1234_5678) begin bad++; $display("FAIL b2b_wdata: got %0h want 12345678", bus.memWriteData); end
    total++; if (bus.memWriteMask !== 4'b0011) begin bad++; $display("FAIL b2b_wmask: got %0b want 0011", bus.memWriteMask); end
    total++; if (bus.reqReadData[0] !== 32'hCAFE_F00D) begin bad++; $display("FAIL b2b_rdata0: got %0h want cafef00d", bus.reqReadData[0]); end
    total++; if (bus.reqReadData[1] !== 32'h0) begin bad++; $display("FAIL b2b_rdata1: got %0h want 0", bus.reqReadData[1]); end
    tick();
    bus.reqEnable   = 2'b00;
    bus.memReadData = 32'h0BAD_BEEF;
    @(negedge clk);
    total++; if (bus.reqReadData[0] !== 32'h0BAD_BEEF) begin bad++; $display("FAIL b2b_owner_kept: got %0h want badbeef", bus.reqReadData[0]); end
    total++; if (bus.reqReadData[1] !== 32'h0) begin bad++; $display("FAIL b2b_owner_other: got %0h want 0", bus.reqReadData[1]); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_locked();
    do_reset();
    bus.reqAddr[0]   = 32'h100;
    bus.reqAddr[1]   = 32'h200;
    bus.reqEnable[0] = 1'b1;
    tick();
    bus.reqEnable = 2'b10;
    bus.memHold   = 1'b1;
    tick();
    bus.reqEnable = 2'b11;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h200) begin bad++; $display("FAIL rstlock_locked: got %0h want 200", bus.memAddr); end
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    bus.memHold = 1'b0;
    @(negedge clk);
    total++; if (bus.memAddr !== 32'h100) begin bad++; $display("FAIL rstlock_addr: got %0h want 100", bus.memAddr); end
    total++; if (bus.reqHold !== 2'b10) begin bad++; $display("FAIL rstlock_hold: got %0b want 10", bus.reqHold); end
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    tick();
    test_reset();
    test_single_read();
    test_rotation();
    test_lock();
    test_back_to_back();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
